bram_dump_reader: RTL

Hardware readback engine for a bram32 instance such as the data BRAM. It is the read-side counterpart of the testbench/host write-loading path. On a start command it walks a contiguous, word-aligned address range through the BRAM debug read port. Each word is presented on a valid/ready output stream, for example toward a UART TX or a bench scoreboard, and the engine accumulates a running checksum. Its purpose is post-execution memory verification without hierarchical peeks.

---
 rtl/bram_dump_reader_pkg.sv | 21 ++
 rtl/bram_dump_reader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bram_dump_reader_pkg.sv
// Shared widths and FSM encoding for the BRAM dump reader.
package bram_dump_reader_pkg;

  localparam int unsigned D_BRAM_ADDR_WIDTH = 10;
  localparam int unsigned DUMP_DATA_WIDTH   = 32;
  localparam int unsigned LAT_CNT_W         = 2;

  // Fixed 3-bit encodings so benches can decode the state directly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

  function automatic logic is_busy_state(input dump_state_e s);
    return (s == ST_READ) || (s == ST_WAIT) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/bram_dump_reader.sv
// Walks a word-aligned BRAM range through the debug read port and streams
// each word out on a valid/ready port while accumulating a checksum.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = D_BRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DUMP_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] checksum
);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] dbg_addr_d, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_d, checksum_d;
  logic                  busy_d, done_d, out_valid_d;
  logic [ADDR_WIDTH-1:0] aligned_base, next_addr;

  assign aligned_base = base_addr & ~ADDR_WIDTH'(3);
  assign next_addr    = cur_addr_q + ADDR_WIDTH'(4);

  // State and every output are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      dbg_addr    <= '0;
      out_data    <= '0;
      out_addr    <= '0;
      checksum    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      lat_cnt_q   <= lat_cnt_d;
      dbg_addr    <= dbg_addr_d;
      out_data    <= out_data_d;
      out_addr    <= out_addr_d;
      checksum    <= checksum_d;
      busy        <= busy_d;
      done        <= done_d;
      out_valid   <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    lat_cnt_d   = lat_cnt_q;
    dbg_addr_d  = dbg_addr;
    out_data_d  = out_data;
    out_addr_d  = out_addr;
    checksum_d  = checksum;

    // Abort wins over any handshake in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_addr_d  = aligned_base;
            remaining_d = word_count;
            checksum_d  = '0;
            if (word_count == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_READ;
              dbg_addr_d = aligned_base;
            end
          end
        end
        ST_READ: begin
          lat_cnt_d = LAT_CNT_W'(READ_LATENCY);
          if (READ_LATENCY == 0) begin
            out_data_d = dbg_data;
            out_addr_d = cur_addr_q;
            state_d    = ST_SEND;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
          if (lat_cnt_q <= LAT_CNT_W'(1)) begin
            out_data_d = dbg_data;
            out_addr_d = cur_addr_q;
            state_d    = ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            checksum_d  = checksum + out_data;
            remaining_d = remaining_q - ADDR_WIDTH'(1);
            cur_addr_d  = next_addr;
            if (remaining_q == ADDR_WIDTH'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_READ;
              dbg_addr_d = next_addr;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d      = is_busy_state(state_d);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_SEND);
  end

endmodule
